// File: rtl/dpram_pkg.sv
// Shared types and constants for the parametrised dual-port RAM.
package dpram_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } collide_mode_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dpram_state_e;

    localparam int LAT_MAX = 2;

endpackage

// File: rtl/dpram_init_ctrl.sv
// Post-reset sweep controller: walks every address once, then hands the
// write port over to normal traffic.
module dpram_init_ctrl
    import dpram_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr
);

    dpram_state_e state;

    // The last address of the sweep is written on the same edge that leaves INIT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= INIT;
            init_addr <= '0;
            init_busy <= 1'b1;
            init_we   <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    init_addr <= init_addr + ADDR_W'(1);
                    if (&init_addr) begin
                        state     <= RUN;
                        init_busy <= 1'b0;
                        init_we   <= 1'b0;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: rtl/dpram_param.sv
// Parametrised single-clock dual-port RAM with byte enables, selectable read
// latency, collision policy and a zeroing sweep after reset.
module dpram_param
    import dpram_pkg::*;
#(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 8,
    parameter int RD_LATENCY   = 1,
    parameter int COLLIDE_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   r_data,
    output logic                r_valid,
    output logic                collision,
    output logic                init_busy
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int BE_W  = DATA_W/8;
    localparam bit NEW_DATA_ON_HIT = (COLLIDE_MODE == int'(WRITE_FIRST));

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > LAT_MAX) begin : g_bad_latency
            $error("dpram_param: RD_LATENCY must be 1 or 2");
        end
        if (DATA_W % 8 != 0) begin : g_bad_width
            $error("dpram_param: DATA_W must be a multiple of 8");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;

    dpram_init_ctrl #(.ADDR_W(ADDR_W)) u_init_ctrl (
        .clk       (clk),
        .rst       (rst),
        .init_busy (init_busy),
        .init_we   (init_we),
        .init_addr (init_addr)
    );

    logic run_wr;
    logic run_rd;
    logic hit;

    assign run_wr = rst && !init_busy && wr_en;
    assign run_rd = rst && !init_busy && rd_en;
    assign hit    = run_wr && run_rd && (wr_addr == rd_addr);

    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged;

    assign old_word = mem[rd_addr];

    // Merge only matters on a hit, where rd_addr equals wr_addr.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (wr_be[i]) begin
                merged[8*i +: 8] = w_data[8*i +: 8];
            end
        end
    end

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;

    assign mem_we    = rst && (init_we || run_wr);
    assign mem_waddr = init_we ? init_addr : wr_addr;
    assign mem_wdata = init_we ? '0 : w_data;
    assign mem_be    = init_we ? '1 : wr_be;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (mem_be[i]) begin
                    mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;
    logic              s1_coll;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
            s1_coll  <= 1'b0;
        end else begin
            s1_valid <= run_rd;
            s1_coll  <= hit;
            if (run_rd) begin
                s1_data <= (hit && NEW_DATA_ON_HIT) ? merged : old_word;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            // Extra output stage; data only moves on a completed read so it holds otherwise.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_data    <= '0;
                    r_valid   <= 1'b0;
                    collision <= 1'b0;
                end else begin
                    r_valid   <= s1_valid;
                    collision <= s1_coll;
                    if (s1_valid) begin
                        r_data <= s1_data;
                    end
                end
            end
        end else begin : g_lat1
            assign r_data    = s1_data;
            assign r_valid   = s1_valid;
            assign collision = s1_coll;
        end
    endgenerate

endmodule

// File: tb/tb_dpram_param.sv
// Runs four RAM configurations (latency 1/2 x read-first/write-first) in lockstep
// against an array-based reference model.
module tb_dpram_param;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] w_data;
    logic [1:0]  wr_be;
    logic        rd_en;
    logic [4:0]  rd_addr;

    logic [15:0] rData  [4];
    logic        rValid [4];
    logic        coll   [4];
    logic        busy   [4];

    typedef struct packed {
        logic        v;
        logic        c;
        logic [15:0] d;
    } res_t;

    logic [15:0] modelMem [32];
    int          busyLeft;
    res_t        expRes [4];
    res_t        prevRF;
    res_t        prevWF;
    int          testsRun;
    int          testsFailed;
    int          cycle;

    dpram_param #(.ADDR_W(5), .DATA_W(16), .RD_LATENCY(1), .COLLIDE_MODE(0)) u_l1_rf (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .w_data(w_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .r_data(rData[0]),
        .r_valid(rValid[0]), .collision(coll[0]), .init_busy(busy[0]));

    dpram_param #(.ADDR_W(5), .DATA_W(16), .RD_LATENCY(1), .COLLIDE_MODE(1)) u_l1_wf (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .w_data(w_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .r_data(rData[1]),
        .r_valid(rValid[1]), .collision(coll[1]), .init_busy(busy[1]));

    dpram_param #(.ADDR_W(5), .DATA_W(16), .RD_LATENCY(2), .COLLIDE_MODE(0)) u_l2_rf (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .w_data(w_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .r_data(rData[2]),
        .r_valid(rValid[2]), .collision(coll[2]), .init_busy(busy[2]));

    dpram_param #(.ADDR_W(5), .DATA_W(16), .RD_LATENCY(2), .COLLIDE_MODE(1)) u_l2_wf (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .w_data(w_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .r_data(rData[3]),
        .r_valid(rValid[3]), .collision(coll[3]), .init_busy(busy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s cycle %0d: got 0x%0h, expected 0x%0h",
                     tag, cycle, observed, expected);
        end
    endtask

    // Non-valid cycles keep the previously returned data.
    function automatic res_t advance(input res_t held, input res_t incoming);
        res_t r;
        if (incoming.v) begin
            r = incoming;
        end else begin
            r = '{1'b0, 1'b0, held.d};
        end
        return r;
    endfunction

    task automatic applyStimulus(input bit rstV, input bit we, input logic [4:0] wa,
                                 input logic [15:0] wd, input logic [1:0] be,
                                 input bit re, input logic [4:0] ra);
        res_t        curRF;
        res_t        curWF;
        logic [15:0] mask;
        logic [15:0] oldWord;
        bit          hitV;
        rst     = rstV;
        wr_en   = we;
        wr_addr = wa;
        w_data  = wd;
        wr_be   = be;
        rd_en   = re;
        rd_addr = ra;
        mask    = {{8{be[1]}}, {8{be[0]}}};
        if (!rstV) begin
            busyLeft = 32;
            for (int k = 0; k < 32; k++) modelMem[k] = 16'h0000;
            for (int k = 0; k < 4; k++) expRes[k] = '0;
            prevRF = '0;
            prevWF = '0;
        end else begin
            curRF = '0;
            curWF = '0;
            if (busyLeft > 0) begin
                busyLeft--;
            end else begin
                if (re) begin
                    oldWord = modelMem[ra];
                    hitV    = we && (wa == ra);
                    curRF   = '{1'b1, hitV, oldWord};
                    curWF   = '{1'b1, hitV, hitV ? ((oldWord & ~mask) | (wd & mask)) : oldWord};
                end
                if (we) modelMem[wa] = (modelMem[wa] & ~mask) | (wd & mask);
            end
            expRes[0] = advance(expRes[0], curRF);
            expRes[1] = advance(expRes[1], curWF);
            expRes[2] = advance(expRes[2], prevRF);
            expRes[3] = advance(expRes[3], prevWF);
            prevRF = curRF;
            prevWF = curWF;
        end
        @(posedge clk);
        @(negedge clk);
        cycle++;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("r_valid[%0d]", k), 32'(rValid[k]), 32'(expRes[k].v));
            checkOutput($sformatf("collision[%0d]", k), 32'(coll[k]), 32'(expRes[k].c));
            checkOutput($sformatf("r_data[%0d]", k), 32'(rData[k]), 32'(expRes[k].d));
            checkOutput($sformatf("init_busy[%0d]", k), 32'(busy[k]), 32'(busyLeft > 0));
        end
    endtask

    task automatic idleRandom(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          16'($urandom), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end
    endtask

    initial begin
        logic [4:0] wa;
        testsRun    = 0;
        testsFailed = 0;
        cycle       = 0;
        busyLeft    = 32;
        prevRF      = '0;
        prevWF      = '0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 5'd0, 16'h0, 2'b00, 1'b0, 5'd0);
        idleRandom(32);

        for (int a = 0; a < 32; a++) applyStimulus(1'b1, 1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'(a));
        applyStimulus(1'b1, 1'b0, 5'd0, 16'h0, 2'b00, 1'b0, 5'd0);

        applyStimulus(1'b1, 1'b1, 5'd7, 16'hA1B2, 2'b11, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b1, 5'd7, 16'hFFFF, 2'b01, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd7);
        checkOutput("be_merge_l1", 32'(rData[0]), 32'h0000_A1FF);
        applyStimulus(1'b1, 1'b0, 5'd0, 16'h0, 2'b00, 1'b0, 5'd0);
        checkOutput("be_merge_l2", 32'(rData[2]), 32'h0000_A1FF);

        applyStimulus(1'b1, 1'b1, 5'd3, 16'h1234, 2'b11, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd3);
        checkOutput("lat2_not_yet", 32'(rValid[2]), 32'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 16'h0, 2'b00, 1'b0, 5'd0);
        checkOutput("lat2_valid", 32'(rValid[2]), 32'd1);
        checkOutput("lat2_data", 32'(rData[2]), 32'h0000_1234);

        applyStimulus(1'b1, 1'b1, 5'd5, 16'h0011, 2'b11, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b1, 5'd5, 16'h2233, 2'b11, 1'b1, 5'd5);
        checkOutput("coll_read_first", 32'(rData[0]), 32'h0000_0011);
        checkOutput("coll_write_first", 32'(rData[1]), 32'h0000_2233);
        checkOutput("coll_flag", 32'(coll[0]), 32'd1);
        applyStimulus(1'b1, 1'b1, 5'd5, 16'h4455, 2'b00, 1'b1, 5'd5);
        applyStimulus(1'b1, 1'b0, 5'd0, 16'h0, 2'b00, 1'b0, 5'd0);

        applyStimulus(1'b1, 1'b1, 5'd31, 16'hBEEF, 2'b11, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b1, 5'd0, 16'hCAFE, 2'b11, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd31);
        applyStimulus(1'b1, 1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd0);
        checkOutput("wrap_second_l1", 32'(rData[0]), 32'h0000_CAFE);
        applyStimulus(1'b1, 1'b0, 5'd0, 16'h0, 2'b00, 1'b0, 5'd0);

        applyStimulus(1'b1, 1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd31);
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0, 2'b00, 1'b0, 5'd0);
        checkOutput("midreset_no_valid", 32'(rValid[2]), 32'd0);
        idleRandom(32);
        applyStimulus(1'b1, 1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd31);

        for (int i = 0; i < 1500; i++) begin
            wa = 5'($urandom_range(0, 31));
            applyStimulus(($urandom_range(0, 399) != 0), 1'($urandom_range(0, 1)), wa,
                          16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
